// File: rtl/aes_trace_driver.sv
// aes_trace_driver: runs a chained batch of AES core operations, triggers the scope
// per operation and streams each block's input and result out as 32 bytes.
module aes_trace_driver #(
    parameter logic [127:0] SEED         = 128'h00112233445566778899aabbccddeeff,
    parameter int           BUSY_WAIT    = 4,
    parameter int           DONE_TIMEOUT = 255,
    parameter int           GAP_CYCLES   = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start_i,
    input  logic [15:0]  count_i,
    input  logic         dec_i,
    output logic         core_load_o,
    output logic [127:0] core_data_o,
    output logic         core_dec_o,
    input  logic         core_busy_i,
    input  logic [127:0] core_data_i,
    output logic         trig_o,
    output logic [7:0]   byte_o,
    output logic         byte_valid_o,
    input  logic         byte_ready_i,
    output logic         busy_o,
    output logic         done_o,
    output logic         err_o
);
    typedef enum logic [2:0] {IDLE, LOAD, WAIT_BUSY, WAIT_DONE, SEND, GAP, FINISH} state_t;

    localparam logic [7:0] BW = 8'(BUSY_WAIT);
    localparam logic [7:0] DT = 8'(DONE_TIMEOUT);
    localparam logic [7:0] GC = 8'(GAP_CYCLES);

    state_t        state_q, state_d;
    logic [15:0]   remaining_q, remaining_d;
    logic [127:0]  data_q, data_d, result_q, result_d;
    logic          dec_q, dec_d, err_q, err_d;
    logic [4:0]    idx_q, idx_d;
    logic [7:0]    cnt_q, cnt_d;
    logic [7:0]    cnt_inc;
    logic [127:0]  blk;

    assign cnt_inc = cnt_q + 8'd1;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            remaining_q <= '0;
            data_q      <= '0;
            result_q    <= '0;
            dec_q       <= 1'b0;
            err_q       <= 1'b0;
            idx_q       <= '0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            data_q      <= data_d;
            result_q    <= result_d;
            dec_q       <= dec_d;
            err_q       <= err_d;
            idx_q       <= idx_d;
            cnt_q       <= cnt_d;
        end
    end

    // The wait counter holds cycles elapsed since the load pulse while in WAIT_BUSY.
    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        data_d      = data_q;
        result_d    = result_q;
        dec_d       = dec_q;
        err_d       = err_q;
        idx_d       = idx_q;
        cnt_d       = cnt_q;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    err_d = 1'b0;
                    if (count_i != 16'd0) begin
                        remaining_d = count_i;
                        dec_d       = dec_i;
                        data_d      = SEED;
                        state_d     = LOAD;
                    end else begin
                        state_d = FINISH;
                    end
                end
            end
            LOAD: begin
                cnt_d   = 8'd1;
                state_d = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                if (core_busy_i) begin
                    cnt_d   = '0;
                    state_d = WAIT_DONE;
                end else if (cnt_inc == BW) begin
                    err_d   = 1'b1;
                    state_d = FINISH;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            WAIT_DONE: begin
                if (!core_busy_i) begin
                    result_d = core_data_i;
                    idx_d    = '0;
                    state_d  = SEND;
                end else if (cnt_inc == DT) begin
                    err_d   = 1'b1;
                    state_d = FINISH;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            SEND: begin
                if (byte_ready_i) begin
                    idx_d = idx_q + 5'd1;
                    if (idx_q == 5'd31) begin
                        data_d      = result_q;
                        remaining_d = remaining_q - 16'd1;
                        cnt_d       = '0;
                        state_d     = (remaining_q == 16'd1) ? FINISH : (GC == 8'd0) ? LOAD : GAP;
                    end
                end
            end
            GAP: begin
                cnt_d   = cnt_inc;
                state_d = (cnt_inc == GC) ? LOAD : GAP;
            end
            FINISH:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Bytes 0-15 come from the block input, 16-31 from the result, MSB byte first.
    assign blk          = idx_q[4] ? result_q : data_q;
    assign byte_o       = (state_q == SEND) ? blk[{~idx_q[3:0], 3'b000} +: 8] : 8'h00;
    assign byte_valid_o = (state_q == SEND);
    assign core_load_o  = (state_q == LOAD);
    assign trig_o       = (state_q == LOAD) || (state_q == WAIT_BUSY) || (state_q == WAIT_DONE);
    assign core_data_o  = data_q;
    assign core_dec_o   = dec_q;
    assign busy_o       = (state_q != IDLE);
    assign done_o       = (state_q == FINISH);
    assign err_o        = err_q;
endmodule

// File: tb/tb_aes_trace_driver.sv
// tb_aes_trace_driver: directed scenarios against a stub AES core (result = input inverted).
module tb_aes_trace_driver;
    localparam logic [127:0] SEED = 128'h00112233445566778899aabbccddeeff;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start_i = 1'b0;
    logic [15:0]  count_i = '0;
    logic         dec_i = 1'b0;
    logic         core_load_o, core_dec_o, core_busy_i, trig_o;
    logic [127:0] core_data_o, core_data_i;
    logic [7:0]   byte_o;
    logic         byte_valid_o, byte_ready_i, busy_o, done_o, err_o;

    int tests = 0;
    int fails = 0;
    int cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    aes_trace_driver dut (
        .clk(clk), .rst_n(rst_n), .start_i(start_i), .count_i(count_i), .dec_i(dec_i),
        .core_load_o(core_load_o), .core_data_o(core_data_o), .core_dec_o(core_dec_o),
        .core_busy_i(core_busy_i), .core_data_i(core_data_i), .trig_o(trig_o),
        .byte_o(byte_o), .byte_valid_o(byte_valid_o), .byte_ready_i(byte_ready_i),
        .busy_o(busy_o), .done_o(done_o), .err_o(err_o)
    );

    // Stub core: busy from the cycle after load for stub_lat cycles.
    int           stub_lat = 44;
    int           busy_cnt = 0;
    logic [127:0] stub_res = '0;
    always @(posedge clk) begin
        if (core_load_o) begin
            busy_cnt <= stub_lat;
            stub_res <= ~core_data_o;
        end else if (busy_cnt > 0) begin
            busy_cnt <= busy_cnt - 1;
        end
    end
    assign core_busy_i = busy_cnt > 0;
    assign core_data_i = stub_res;

    // Ready pattern 1,0,0 repeating when backpressure is enabled.
    int   ph = 0;
    logic bp_en = 1'b0;
    always @(posedge clk) ph <= (ph == 2) ? 0 : ph + 1;
    assign byte_ready_i = !bp_en || ph == 0;

    logic [7:0]   bytes[$];
    int           byte_cyc[$];
    logic [127:0] load_data[$];
    int           load_cyc[$];
    int           n_trig = 0, n_done = 0, done_cyc = 0, stall_bad = 0;
    logic         prev_stall = 1'b0;
    logic [7:0]   prev_byte = '0;

    always @(negedge clk) begin
        if (prev_stall && byte_o !== prev_byte) stall_bad++;
        prev_stall = byte_valid_o && !byte_ready_i;
        prev_byte  = byte_o;
        if (byte_valid_o && byte_ready_i) begin
            bytes.push_back(byte_o);
            byte_cyc.push_back(cyc);
        end
        if (core_load_o) begin
            load_data.push_back(core_data_o);
            load_cyc.push_back(cyc);
        end
        if (trig_o) n_trig++;
        if (done_o) begin
            n_done++;
            done_cyc = cyc;
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    function automatic logic [7:0] exp_byte(input logic [127:0] in, input int i);
        logic [255:0] b;
        b = {in, ~in};
        return b[255 - 8 * i -: 8];
    endfunction

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic clear_mon();
        bytes.delete();
        byte_cyc.delete();
        load_data.delete();
        load_cyc.delete();
        n_trig = 0;
        n_done = 0;
        stall_bad = 0;
        prev_stall = 1'b0;
    endtask

    task automatic start_batch(input logic [15:0] n, input logic d);
        start_i = 1'b1;
        count_i = n;
        dec_i   = d;
        step();
        start_i = 1'b0;
        count_i = '0;
        dec_i   = 1'b0;
    endtask

    task automatic wait_done(input int budget, input string name);
        int k = 0;
        while (n_done == 0 && k < budget) begin
            step();
            k++;
        end
        tests++;
        if (n_done == 0) begin
            fails++;
            $display("FAIL %s: done_o not seen within %0d cycles", name, budget);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        step();
        step();
        tests++;
        if ({core_load_o, core_data_o, core_dec_o, trig_o, byte_o, byte_valid_o, busy_o, done_o, err_o} !== '0) begin
            fails++;
            $display("FAIL reset_outputs: got load=%b data=%h dec=%b trig=%b byte=%h valid=%b busy=%b done=%b err=%b, want all 0",
                     core_load_o, core_data_o, core_dec_o, trig_o, byte_o, byte_valid_o, busy_o, done_o, err_o);
        end
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_single();
        int l, bad;
        clear_mon();
        stub_lat = 44;
        start_batch(1, 1'b0);
        l = cyc;
        tests++;
        if (!(core_load_o === 1'b1 && trig_o === 1'b1 && busy_o === 1'b1 && core_data_o === SEED)) begin
            fails++;
            $display("FAIL single_load: load=%b trig=%b busy=%b data=%h, want 1 1 1 %h", core_load_o, trig_o, busy_o, core_data_o, SEED);
        end
        wait_done(300, "single_done");
        bad = 0;
        foreach (bytes[i]) if (i < 32 && bytes[i] !== exp_byte(SEED, i)) bad++;
        tests++;
        if (bytes.size() != 32 || bad != 0) begin
            fails++;
            $display("FAIL single_stream: %0d bytes, %0d wrong, want 32 bytes 0 wrong", bytes.size(), bad);
        end
        tests++;
        if (load_cyc.size() != 1 || n_trig != 46) begin
            fails++;
            $display("FAIL single_load_trig: loads=%0d trig_cycles=%0d, want 1 and 46", load_cyc.size(), n_trig);
        end
        tests++;
        if (bytes.size() != 32 || done_cyc != byte_cyc[31] + 1 || done_cyc != l + 78) begin
            fails++;
            $display("FAIL single_done_time: done at %0d, want %0d", done_cyc - l, 78);
        end
        tests++;
        if (err_o !== 1'b0 || busy_o !== 1'b0 || done_o !== 1'b0 || n_done != 1 || core_data_o !== ~SEED) begin
            fails++;
            $display("FAIL single_end: err=%b busy=%b done=%b pulses=%0d data=%h, want 0 0 0 1 %h", err_o, busy_o, done_o, n_done, core_data_o, ~SEED);
        end
    endtask

    task automatic test_chain();
        clear_mon();
        start_batch(3, 1'b1);
        tests++;
        if (core_dec_o !== 1'b1) begin
            fails++;
            $display("FAIL chain_dec: got %b want 1", core_dec_o);
        end
        wait_done(1000, "chain_done");
        tests++;
        if (load_cyc.size() != 3 || bytes.size() != 96) begin
            fails++;
            $display("FAIL chain_counts: loads=%0d bytes=%0d, want 3 and 96", load_cyc.size(), bytes.size());
        end else begin
            tests++;
            if (load_data[0] !== SEED || load_data[1] !== ~SEED || load_data[2] !== SEED) begin
                fails++;
                $display("FAIL chain_inputs: got %h %h %h", load_data[0], load_data[1], load_data[2]);
            end
            tests++;
            if (load_cyc[1] - byte_cyc[31] != 17 || load_cyc[2] - byte_cyc[63] != 17) begin
                fails++;
                $display("FAIL chain_gap: got %0d and %0d, want 17", load_cyc[1] - byte_cyc[31], load_cyc[2] - byte_cyc[63]);
            end
        end
    endtask

    task automatic test_backpressure();
        int bad;
        clear_mon();
        bp_en = 1'b1;
        start_batch(1, 1'b0);
        wait_done(400, "bp_done");
        bp_en = 1'b0;
        bad = 0;
        foreach (bytes[i]) if (i < 32 && bytes[i] !== exp_byte(SEED, i)) bad++;
        tests++;
        if (bytes.size() != 32 || bad != 0 || stall_bad != 0) begin
            fails++;
            $display("FAIL bp_stream: %0d bytes, %0d wrong, %0d unstable stalls, want 32 0 0", bytes.size(), bad, stall_bad);
        end
    endtask

    task automatic test_no_busy();
        clear_mon();
        stub_lat = 0;
        start_batch(1, 1'b0);
        step();
        step();
        step();
        tests++;
        if (err_o !== 1'b0 || trig_o !== 1'b1) begin
            fails++;
            $display("FAIL nobusy_early: err=%b trig=%b at load+3, want 0 1", err_o, trig_o);
        end
        step();
        tests++;
        if (err_o !== 1'b1 || done_o !== 1'b1 || trig_o !== 1'b0) begin
            fails++;
            $display("FAIL nobusy_err: err=%b done=%b trig=%b at load+4, want 1 1 0", err_o, done_o, trig_o);
        end
        step();
        tests++;
        if (bytes.size() != 0 || n_trig != 4 || err_o !== 1'b1 || busy_o !== 1'b0) begin
            fails++;
            $display("FAIL nobusy_after: bytes=%0d trig=%0d err=%b busy=%b, want 0 4 1 0", bytes.size(), n_trig, err_o, busy_o);
        end
        stub_lat = 44;
    endtask

    task automatic test_timeout();
        clear_mon();
        stub_lat = 300;
        start_batch(1, 1'b0);
        repeat (256) step();
        tests++;
        if (err_o !== 1'b0 || trig_o !== 1'b1) begin
            fails++;
            $display("FAIL timeout_early: err=%b trig=%b at load+256, want 0 1", err_o, trig_o);
        end
        step();
        tests++;
        if (err_o !== 1'b1 || done_o !== 1'b1) begin
            fails++;
            $display("FAIL timeout_err: err=%b done=%b at load+257, want 1 1", err_o, done_o);
        end
        repeat (60) step();
        tests++;
        if (bytes.size() != 0 || err_o !== 1'b1) begin
            fails++;
            $display("FAIL timeout_after: bytes=%0d err=%b, want 0 1", bytes.size(), err_o);
        end
        stub_lat = 44;
    endtask

    task automatic test_zero();
        clear_mon();
        start_batch(0, 1'b0);
        tests++;
        if (done_o !== 1'b1 || err_o !== 1'b0 || core_load_o !== 1'b0) begin
            fails++;
            $display("FAIL zero_done: done=%b err=%b load=%b, want 1 0 0", done_o, err_o, core_load_o);
        end
        step();
        tests++;
        if (done_o !== 1'b0 || busy_o !== 1'b0 || load_cyc.size() != 0) begin
            fails++;
            $display("FAIL zero_after: done=%b busy=%b loads=%0d, want 0 0 0", done_o, busy_o, load_cyc.size());
        end
    endtask

    task automatic test_reset_mid_send();
        int k, bad;
        clear_mon();
        start_batch(1, 1'b1);
        k = 0;
        while (bytes.size() < 10 && k < 300) begin
            step();
            k++;
        end
        tests++;
        if (byte_valid_o !== 1'b1 || byte_o !== 8'haa) begin
            fails++;
            $display("FAIL midsend_byte10: valid=%b byte=%h, want 1 aa", byte_valid_o, byte_o);
        end
        rst_n = 1'b0;
        step();
        tests++;
        if ({core_load_o, core_data_o, core_dec_o, trig_o, byte_o, byte_valid_o, busy_o, done_o, err_o} !== '0) begin
            fails++;
            $display("FAIL midsend_reset: data=%h dec=%b valid=%b byte=%h busy=%b, want all 0", core_data_o, core_dec_o, byte_valid_o, byte_o, busy_o);
        end
        rst_n = 1'b1;
        step();
        clear_mon();
        start_batch(1, 1'b0);
        tests++;
        if (core_data_o !== SEED || core_dec_o !== 1'b0) begin
            fails++;
            $display("FAIL midsend_restart: data=%h dec=%b, want %h 0", core_data_o, core_dec_o, SEED);
        end
        wait_done(300, "midsend_done");
        bad = 0;
        foreach (bytes[i]) if (i < 32 && bytes[i] !== exp_byte(SEED, i)) bad++;
        tests++;
        if (bytes.size() != 32 || bad != 0) begin
            fails++;
            $display("FAIL midsend_stream: %0d bytes, %0d wrong, want 32 0", bytes.size(), bad);
        end
    endtask

    task automatic test_start_ignored();
        clear_mon();
        start_batch(2, 1'b0);
        repeat (10) step();
        start_i = 1'b1;
        count_i = 16'd5;
        dec_i   = 1'b1;
        step();
        start_i = 1'b0;
        count_i = '0;
        dec_i   = 1'b0;
        tests++;
        if (core_dec_o !== 1'b0 || core_data_o !== SEED) begin
            fails++;
            $display("FAIL ignore_hold: dec=%b data=%h, want 0 %h", core_dec_o, core_data_o, SEED);
        end
        wait_done(600, "ignore_done");
        tests++;
        if (load_cyc.size() != 2 || bytes.size() != 64) begin
            fails++;
            $display("FAIL ignore_count: loads=%0d bytes=%0d, want 2 64", load_cyc.size(), bytes.size());
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_chain();
        test_backpressure();
        test_no_busy();
        test_timeout();
        test_zero();
        test_reset_mid_send();
        test_start_ignored();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
